// File: rtl/output_wb_pkg.sv
// rtl/output_wb_pkg.sv - shared constants and FSM state type for the output writeback packer
package output_wb_pkg;

    localparam int OUT_SRAM_ROWS      = 6;
    localparam int OUT_SRAM_ROW_DEPTH = 2048;
    localparam int OUT_SRAM_WORDS     = OUT_SRAM_ROWS * OUT_SRAM_ROW_DEPTH;
    localparam int OUT_WORD_W         = 128;
    localparam int OUT_ADDR_W         = 14;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WRITE,
        WAIT,
        DONE
    } owb_state_t;

endpackage

// File: rtl/owb_lane_packer.sv
// rtl/owb_lane_packer.sv - lane counter and pack register; OUTPUT_WB_RELU_EN clamps negative beats to zero
module owb_lane_packer
    import output_wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    load,
    input  logic [DATA_W-1:0]       beat_data,
    input  logic                    beat_last,
    output logic [LANES*DATA_W-1:0] pack_word,
    output logic                    word_full
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANE_W-1:0]       lane_cnt_q, lane_cnt_d;
    logic [LANES*DATA_W-1:0] pack_q, pack_d;
    logic [DATA_W-1:0]       beat_val;

    // Value actually stored for an accepted beat (optionally rectified)
    always_comb begin
`ifdef OUTPUT_WB_RELU_EN
        beat_val = beat_data[DATA_W-1] ? '0 : beat_data;
`else
        beat_val = beat_data;
`endif
    end

    // The word is complete when this beat lands in the top lane or closes the job
    assign word_full = load && ((lane_cnt_q == LANE_W'(LANES - 1)) || beat_last);
    assign pack_word = pack_q;

    // Next lane/pack contents: clear wins so a finished word leaves zeros in unfilled lanes
    always_comb begin
        lane_cnt_d = lane_cnt_q;
        pack_d     = pack_q;
        if (clear) begin
            lane_cnt_d = '0;
            pack_d     = '0;
        end else if (load) begin
            for (int k = 0; k < LANES; k++) begin
                if (lane_cnt_q == LANE_W'(k)) begin
                    pack_d[k*DATA_W +: DATA_W] = beat_val;
                end
            end
            lane_cnt_d = lane_cnt_q + 1'b1;
        end
    end

    // Lane counter and pack register state
    always_ff @(posedge clock) begin
        if (reset) begin
            lane_cnt_q <= '0;
            pack_q     <= '0;
        end else begin
            lane_cnt_q <= lane_cnt_d;
            pack_q     <= pack_d;
        end
    end

endmodule

// File: rtl/output_writeback_packer.sv
// rtl/output_writeback_packer.sv - packs 32-bit results into 128-bit SRAM writes, one outstanding write; option OUTPUT_WB_RELU_EN
module output_writeback_packer
    import output_wb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int LANES     = 4,
    parameter int MAX_WORDS = OUT_SRAM_WORDS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [OUT_ADDR_W-1:0] base_addr,
    input  logic [OUT_ADDR_W-1:0] num_words,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  w_en,
    output logic [31:0]           w_addr,
    output logic [OUT_WORD_W-1:0] w_d,
    input  logic                  w_done,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [OUT_ADDR_W-1:0] words_written
);

    owb_state_t            state_q, state_d;
    logic [OUT_ADDR_W-1:0] addr_q, addr_d;
    logic [OUT_ADDR_W-1:0] num_words_q, num_words_d;
    logic [OUT_ADDR_W-1:0] words_written_q, words_written_d;
    logic                  error_q, error_d;
    logic                  last_seen_q, last_seen_d;
    logic                  in_ready_q, in_ready_d;
    logic                  w_en_q, w_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                    pk_clear;
    logic                    pk_load;
    logic                    pk_full;
    logic [LANES*DATA_W-1:0] pk_word;
    logic [OUT_ADDR_W:0]     end_addr;

    // One extra bit so base+count cannot wrap before the range test
    assign end_addr = {1'b0, base_addr} + {1'b0, num_words};

    // in_ready is only ever high in FILL, so this is the accepted-beat strobe
    assign pk_load = in_ready_q & in_valid;

    owb_lane_packer #(
        .DATA_W (DATA_W),
        .LANES  (LANES)
    ) u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (pk_clear),
        .load      (pk_load),
        .beat_data (in_data),
        .beat_last (in_last),
        .pack_word (pk_word),
        .word_full (pk_full)
    );

    // Job sequencing, address/word counters, and registered handshake outputs
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        num_words_d     = num_words_q;
        words_written_d = words_written_q;
        error_d         = error_q;
        last_seen_d     = last_seen_q;
        pk_clear        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d          = base_addr;
                    num_words_d     = num_words;
                    words_written_d = '0;
                    error_d         = 1'b0;
                    last_seen_d     = 1'b0;
                    if (end_addr > (OUT_ADDR_W+1)'(MAX_WORDS)) begin
                        error_d = 1'b1;
                        state_d = DONE;
                    end else if (num_words == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (pk_load) begin
                    if (in_last) begin
                        last_seen_d = 1'b1;
                    end
                    if (pk_full) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (w_done) begin
                    words_written_d = words_written_q + 1'b1;
                    addr_d          = addr_q + 1'b1;
                    pk_clear        = 1'b1;
                    if ((words_written_d == num_words_q) || last_seen_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == FILL);
        w_en_d     = (state_d == WRITE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    // FSM state and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            num_words_q     <= '0;
            words_written_q <= '0;
            error_q         <= 1'b0;
            last_seen_q     <= 1'b0;
            in_ready_q      <= 1'b0;
            w_en_q          <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            num_words_q     <= num_words_d;
            words_written_q <= words_written_d;
            error_q         <= error_d;
            last_seen_q     <= last_seen_d;
            in_ready_q      <= in_ready_d;
            w_en_q          <= w_en_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign w_en          = w_en_q;
    assign w_addr        = {{(32-OUT_ADDR_W){1'b0}}, addr_q};
    assign w_d           = pk_word;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = words_written_q;

endmodule
